// File: rtl/book_processor_multi.sv
// book_processor_multi
//   Single-instrument price-level book with sequenced add/cancel handling.
//   Keeps a bid and an ask quantity per price level over the window
//   [BASE_PRICE, BASE_PRICE+NUM_LEVELS-1]. When a best level empties, the
//   book walks away from it one level per cycle to find the next best.
//   An order that reaches within EDGE ticks of the opposite best is not
//   booked. Instead, it raises a one-cycle trade pulse.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   msg_valid, msg      168-bit feed message (type/seq/side/price/qty)
//   msg_ready           high only when idle and out of reset
//   signal*             trade pulse with side/price of the crossing order
//   best_bid, best_ask  current best prices (0 / all-ones when empty)
//   seq_expected        next sequence number accepted
//   gap_err, range_err  one-cycle error pulses
//
//   state | meaning
//   IDLE  | accepting messages
//   SCAN  | searching for new best after best level emptied
//   FIRE  | crossing order seen, trade pulse issued on exit
module book_processor_multi #(
  parameter int unsigned NUM_LEVELS = 100,
  parameter int unsigned BASE_PRICE = 50,
  parameter int unsigned EDGE       = 1,
  parameter int unsigned QTY_W      = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         msg_valid,
  input  logic [167:0] msg,
  output logic         msg_ready,
  output logic         signal,
  output logic         signal_side,
  output logic [31:0]  signal_price,
  output logic [31:0]  best_bid,
  output logic [31:0]  best_ask,
  output logic [31:0]  seq_expected,
  output logic         gap_err,
  output logic         range_err
);
  localparam int unsigned IDX_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int unsigned SW    = ((QTY_W > 32) ? QTY_W : 32) + 1;
  localparam logic [QTY_W-1:0] QTY_MAX   = '1;
  localparam logic [31:0]      BASE      = 32'(BASE_PRICE);
  localparam logic [31:0]      EMPTY_ASK = '1;
  localparam logic [IDX_W-1:0] TOP_IDX   = IDX_W'(NUM_LEVELS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, FIRE} state_t;

  state_t             state_q, state_d;
  logic [QTY_W-1:0]   bid_lvl_q [NUM_LEVELS];
  logic [QTY_W-1:0]   ask_lvl_q [NUM_LEVELS];
  logic [31:0]        best_bid_q, best_bid_d, best_ask_q, best_ask_d;
  logic [31:0]        seq_q, seq_d, sig_price_q, sig_price_d;
  logic               sig_q, sig_d, sig_side_q, sig_side_d;
  logic               gap_q, gap_d, range_q, range_d;
  logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
  logic               scan_ask_q, scan_ask_d;
  logic               lvl_we, lvl_ask;
  logic [IDX_W-1:0]   lvl_idx;
  logic [QTY_W-1:0]   lvl_wdata;

  logic [7:0]         m_type;
  logic [31:0]        m_seq, m_price, m_qty, price_off, scan_price;
  logic               m_ask, accept, in_range, bid_cross, ask_cross;
  logic [IDX_W-1:0]   idx;
  logic [QTY_W-1:0]   cur_lvl, add_lvl, cxl_lvl, scan_lvl;
  logic [SW-1:0]      add_sum;
  logic               unused_msg_bits;

  assign m_type  = msg[7:0];
  assign m_seq   = msg[39:8];
  assign m_ask   = |msg[47:40];
  assign m_price = msg[111:80];
  assign m_qty   = msg[143:112];
  assign unused_msg_bits = ^{msg[79:48], msg[167:144]};

  assign msg_ready = rst_n && (state_q == IDLE);
  assign accept    = msg_valid && msg_ready;

  assign price_off = m_price - BASE;
  assign in_range  = (m_price >= BASE) && (price_off < 32'(NUM_LEVELS));
  assign idx       = price_off[IDX_W-1:0];
  assign cur_lvl   = m_ask ? ask_lvl_q[idx] : bid_lvl_q[idx];
  assign add_sum   = SW'(cur_lvl) + SW'(m_qty);
  assign add_lvl   = (add_sum > SW'(QTY_MAX)) ? QTY_MAX : add_sum[QTY_W-1:0];
  assign cxl_lvl   = (SW'(m_qty) >= SW'(cur_lvl)) ? '0 : cur_lvl - QTY_W'(m_qty);

  // 33-bit compares so best +/- EDGE never wraps
  assign bid_cross = (best_ask_q != EMPTY_ASK) &&
                     (({1'b0, m_price} + 33'(EDGE)) >= {1'b0, best_ask_q});
  assign ask_cross = (best_bid_q != '0) &&
                     ({1'b0, m_price} <= ({1'b0, best_bid_q} + 33'(EDGE)));

  assign scan_lvl   = scan_ask_q ? ask_lvl_q[scan_idx_q] : bid_lvl_q[scan_idx_q];
  assign scan_price = BASE + 32'(scan_idx_q);

  always_comb begin
    state_d     = state_q;
    best_bid_d  = best_bid_q;
    best_ask_d  = best_ask_q;
    seq_d       = seq_q;
    sig_d       = (state_q == FIRE);
    sig_side_d  = sig_side_q;
    sig_price_d = sig_price_q;
    gap_d       = 1'b0;
    range_d     = 1'b0;
    scan_idx_d  = scan_idx_q;
    scan_ask_d  = scan_ask_q;
    lvl_we      = 1'b0;
    lvl_ask     = m_ask;
    lvl_idx     = idx;
    lvl_wdata   = add_lvl;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (m_seq != seq_q) begin
            gap_d = 1'b1;
          end else begin
            seq_d = seq_q + 32'd1;
            if (m_type <= 8'd1 && !in_range) begin
              range_d = 1'b1;
            end else if (m_type == 8'd0) begin
              if ((!m_ask && bid_cross) || (m_ask && ask_cross)) begin
                state_d     = FIRE;
                sig_side_d  = m_ask;
                sig_price_d = m_price;
              end else begin
                lvl_we = 1'b1;
                if (!m_ask && m_price > best_bid_q) best_bid_d = m_price;
                if (m_ask && m_price < best_ask_q)  best_ask_d = m_price;
              end
            end else if (m_type == 8'd1) begin
              lvl_we    = 1'b1;
              lvl_wdata = cxl_lvl;
              if (cxl_lvl == '0) begin
                // Emptied best at the window edge has nothing left to scan
                if (!m_ask && m_price == best_bid_q) begin
                  if (idx == '0) best_bid_d = '0;
                  else begin
                    state_d    = SCAN;
                    scan_ask_d = 1'b0;
                    scan_idx_d = idx - IDX_W'(1);
                  end
                end else if (m_ask && m_price == best_ask_q) begin
                  if (idx == TOP_IDX) best_ask_d = EMPTY_ASK;
                  else begin
                    state_d    = SCAN;
                    scan_ask_d = 1'b1;
                    scan_idx_d = idx + IDX_W'(1);
                  end
                end
              end
            end
          end
        end
      end
      SCAN: begin
        if (scan_lvl != '0) begin
          state_d = IDLE;
          if (scan_ask_q) best_ask_d = scan_price;
          else            best_bid_d = scan_price;
        end else if (!scan_ask_q && scan_idx_q == '0) begin
          state_d    = IDLE;
          best_bid_d = '0;
        end else if (scan_ask_q && scan_idx_q == TOP_IDX) begin
          state_d    = IDLE;
          best_ask_d = EMPTY_ASK;
        end else if (scan_ask_q) begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end else begin
          scan_idx_d = scan_idx_q - IDX_W'(1);
        end
      end
      FIRE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      best_bid_q  <= '0;
      best_ask_q  <= EMPTY_ASK;
      seq_q       <= '0;
      sig_q       <= 1'b0;
      sig_side_q  <= 1'b0;
      sig_price_q <= '0;
      gap_q       <= 1'b0;
      range_q     <= 1'b0;
      scan_idx_q  <= '0;
      scan_ask_q  <= 1'b0;
      for (int i = 0; i < int'(NUM_LEVELS); i++) begin
        bid_lvl_q[i] <= '0;
        ask_lvl_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      best_bid_q  <= best_bid_d;
      best_ask_q  <= best_ask_d;
      seq_q       <= seq_d;
      sig_q       <= sig_d;
      sig_side_q  <= sig_side_d;
      sig_price_q <= sig_price_d;
      gap_q       <= gap_d;
      range_q     <= range_d;
      scan_idx_q  <= scan_idx_d;
      scan_ask_q  <= scan_ask_d;
      if (lvl_we) begin
        if (lvl_ask) ask_lvl_q[lvl_idx] <= lvl_wdata;
        else         bid_lvl_q[lvl_idx] <= lvl_wdata;
      end
    end
  end

  assign signal       = sig_q;
  assign signal_side  = sig_side_q;
  assign signal_price = sig_price_q;
  assign best_bid     = best_bid_q;
  assign best_ask     = best_ask_q;
  assign seq_expected = seq_q;
  assign gap_err      = gap_q;
  assign range_err    = range_q;
endmodule

// File: tb/tb_book_processor_multi.sv
// Directed bench for book_processor_multi: drives messages on the falling
// edge and samples outputs on the falling edge after each accept.
module tb_book_processor_multi;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         msg_valid = 1'b0;
  logic [167:0] msg = '0;
  logic         msg_ready, signal, signal_side, gap_err, range_err;
  logic [31:0]  signal_price, best_bid, best_ask, seq_expected;

  int n_checks = 0;
  int n_fails  = 0;
  int n;

  localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

  book_processor_multi dut (
    .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid), .msg(msg),
    .msg_ready(msg_ready), .signal(signal), .signal_side(signal_side),
    .signal_price(signal_price), .best_bid(best_bid), .best_ask(best_ask),
    .seq_expected(seq_expected), .gap_err(gap_err), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [167:0] mk(input logic [7:0] t, input logic [31:0] s,
                                      input logic [7:0] sd, input logic [31:0] p,
                                      input logic [31:0] q);
    logic [167:0] m;
    m = '0;
    m[7:0] = t; m[39:8] = s; m[47:40] = sd; m[111:80] = p; m[143:112] = q;
    return m;
  endfunction

  // Presents a message and holds it until consumed; returns just after the accept edge
  task automatic send(input logic [7:0] t, input logic [31:0] s, input logic [7:0] sd,
                      input logic [31:0] p, input logic [31:0] q);
    int w;
    @(negedge clk);
    msg = mk(t, s, sd, p, q);
    msg_valid = 1'b1;
    w = 0;
    while (!msg_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!msg_ready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 msg_valid = 1'b0;
  endtask

  // Counts falling edges with msg_ready low after an accept
  task automatic ready_low_cycles(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (!msg_ready && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", msg_ready, 0);
    chk("rst_bid", best_bid, 0);
    chk("rst_ask", best_ask, EMPTY);
    chk("rst_seq", seq_expected, 0);
    chk("rst_signal", signal, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", msg_ready, 1);

    // basic adds
    send(0, 0, 0, 60, 5);
    @(negedge clk); chk("add_bid60", best_bid, 60);
    send(0, 1, 1, 70, 3);
    @(negedge clk);
    chk("add_ask70", best_ask, 70);
    chk("seq2", seq_expected, 2);
    chk("no_signal", signal, 0);

    // bid crossing 69 >= 70-1
    send(0, 2, 0, 69, 1);
    @(negedge clk);
    chk("fire1_sig", signal, 0);
    chk("fire1_ready", msg_ready, 0);
    chk("fire1_bid", best_bid, 60);
    chk("fire1_seq", seq_expected, 3);
    @(negedge clk);
    chk("fire2_sig", signal, 1);
    chk("fire2_side", signal_side, 0);
    chk("fire2_price", signal_price, 69);
    @(negedge clk);
    chk("fire3_sig", signal, 0);

    // second bid level and equal-price accumulate at best
    send(0, 3, 0, 55, 2);
    @(negedge clk); chk("bid55_best", best_bid, 60);
    send(0, 4, 0, 60, 1);
    @(negedge clk); chk("eq_add_best", best_bid, 60);

    // empty best bid 60 (qty 6) -> scan 59..55
    send(1, 5, 0, 60, 6);
    ready_low_cycles(n);
    chk("scan_bid_len", n, 5);
    chk("scan_bid_best", best_bid, 55);
    // over-cancel 55 -> scan to index 0, empty
    send(1, 6, 0, 55, 9);
    ready_low_cycles(n);
    chk("scan_bid0_len", n, 5);
    chk("scan_bid0_best", best_bid, 0);
    // empty best ask 70 -> scan 71..149, empty
    send(1, 7, 1, 70, 3);
    ready_low_cycles(n);
    chk("scan_ask_len", n, 79);
    chk("scan_ask_best", best_ask, EMPTY);

    // gap then range errors
    send(0, 10, 0, 60, 1);
    @(negedge clk);
    chk("gap_pulse", gap_err, 1);
    chk("gap_seq", seq_expected, 8);
    chk("gap_bid", best_bid, 0);
    @(negedge clk); chk("gap_clear", gap_err, 0);
    send(0, 8, 0, 200, 1);
    @(negedge clk);
    chk("range_hi", range_err, 1);
    chk("range_seq", seq_expected, 9);
    chk("range_bid", best_bid, 0);
    @(negedge clk); chk("range_clear", range_err, 0);
    send(1, 9, 1, 49, 1);
    @(negedge clk);
    chk("range_lo", range_err, 1);
    chk("range_lo_seq", seq_expected, 10);

    // top of window, then ask crossing 101 <= 100+1
    send(0, 10, 1, 149, 1);
    @(negedge clk);
    chk("ask149", best_ask, 149);
    chk("ask149_rerr", range_err, 0);
    send(0, 11, 0, 100, 1);
    @(negedge clk); chk("bid100", best_bid, 100);
    send(0, 12, 1, 101, 1);
    @(negedge clk); chk("afire1_sig", signal, 0);
    @(negedge clk);
    chk("afire2_sig", signal, 1);
    chk("afire2_side", signal_side, 1);
    chk("afire2_price", signal_price, 101);
    chk("afire2_ask", best_ask, 149);
    send(0, 13, 1, 102, 1);
    @(negedge clk);
    chk("ask102", best_ask, 102);
    chk("ask102_sig", signal, 0);

    // unknown type
    send(7, 14, 0, 120, 1);
    @(negedge clk);
    chk("unk_seq", seq_expected, 15);
    chk("unk_bid", best_bid, 100);

    // reset in the middle of a scan
    send(1, 15, 0, 100, 1);
    @(negedge clk);
    @(negedge clk);
    chk("midscan_ready", msg_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_ready", msg_ready, 0);
    chk("mrst_bid", best_bid, 0);
    chk("mrst_ask", best_ask, EMPTY);
    chk("mrst_seq", seq_expected, 0);
    @(negedge clk);
    chk("mrst_ready2", msg_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_rel", msg_ready, 1);

    // ask 102 held qty 1 before reset; a cleared level empties on one cancel
    send(0, 0, 1, 102, 1);
    send(1, 1, 1, 102, 1);
    // presented while scanning: must wait and be consumed once
    send(0, 2, 0, 50, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("clr_ask", best_ask, EMPTY);
    chk("held_bid", best_bid, 50);
    chk("held_seq", seq_expected, 3);

    // saturation at level 50
    send(0, 3, 0, 50, 32'hFFFF_FFFF);
    send(1, 4, 0, 50, 1);
    @(negedge clk); chk("sat_c1", best_bid, 50);
    send(1, 5, 0, 50, 32'hFFFF_FFFD);
    @(negedge clk); chk("sat_c2", best_bid, 50);
    send(1, 6, 0, 50, 1);
    @(negedge clk);
    chk("sat_empty", best_bid, 0);
    chk("sat_ready", msg_ready, 1);
    chk("sat_seq", seq_expected, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
